// File: rtl/dsp_mac_pkg.sv
// Shared constants and lane result bundle for the feedback MAC lanes.
// Build option: DSP_MAC_SATURATE_EN selects clamping instead of wrapping.
package dsp_mac_pkg;

  localparam int DEF_LANES = 2;
  localparam int DEF_A_W   = 10;
  localparam int DEF_B_W   = 9;
  localparam int DEF_OUT_W = 19;
  localparam int DEF_SHIFT = 2;

  // Wide enough for any sensible OUT_W; lanes zero-extend into it.
  localparam int RES_MAX_W = 64;

  typedef struct packed {
    logic [RES_MAX_W-1:0] value;
    logic                 ovf;
  } lane_res_t;

endpackage

// File: rtl/dsp_feedback_mac_lanes_if.sv
// Per-lane operand/result bundle between the top and one MAC lane.
// Build option: none (see DSP_MAC_SATURATE_EN in the lane).
interface dsp_feedback_mac_lanes_if #(
  parameter int A_W = 10,
  parameter int B_W = 9
);
  import dsp_mac_pkg::*;

  logic           vld;
  logic           clr;
  logic           sub;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  lane_res_t      res;

  modport master (
    output vld, clr, sub, a, b,
    input  res
  );

  modport slave (
    input  vld, clr, sub, a, b,
    output res
  );

endinterface

// File: rtl/dsp_mac_lane.sv
// One feedback multiply-accumulate lane with sticky range flag.
// Build option: DSP_MAC_SATURATE_EN clamps instead of wrapping.
module dsp_mac_lane
  import dsp_mac_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input logic clk_i,
  input logic rst_ni,
  dsp_feedback_mac_lanes_if.slave bus
);

  // Signed width that holds shifted A plus or minus the full product.
  localparam int FW = A_W + SHIFT + A_W + B_W + 2;

  logic [OUT_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [A_W+B_W-1:0]   prod;
  logic signed [FW-1:0] base, fb, nxt;
  logic                 rng_err;
  logic [OUT_W-1:0]     val;

  always_comb begin
    prod    = bus.clr ? '0 : (A_W+B_W)'(acc_q[A_W-1:0]) * (A_W+B_W)'(bus.b);
    base    = $signed(FW'(bus.a) << SHIFT);
    fb      = $signed(FW'(prod));
    nxt     = bus.sub ? (base - fb) : (base + fb);
    rng_err = (nxt[FW-1:OUT_W] != '0);
`ifdef DSP_MAC_SATURATE_EN
    if (nxt[FW-1])
      val = '0;
    else if (rng_err)
      val = '1;
    else
      val = nxt[OUT_W-1:0];
`else
    val = nxt[OUT_W-1:0];
`endif
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (bus.vld) begin
      acc_d = val;
      ovf_d = rng_err | (ovf_q & ~bus.clr);
    end else if (bus.clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.res.value = RES_MAX_W'(acc_q);
  assign bus.res.ovf   = ovf_q;

endmodule

// File: rtl/dsp_feedback_mac_lanes.sv
// Multi-lane feedback MAC: lanes plus shared out_valid and beat counter.
// Build option: DSP_MAC_SATURATE_EN clamps lane results instead of wrapping.
module dsp_feedback_mac_lanes
  import dsp_mac_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [LANES*A_W-1:0]   a,
  input  logic [LANES*B_W-1:0]   b,
  input  logic                   subtract,
  input  logic                   clear,
  output logic [LANES*OUT_W-1:0] z_out,
  output logic                   out_valid,
  output logic [LANES-1:0]       overflow,
  output logic [15:0]            beat_cnt
);

  logic        vld_q, vld_d;
  logic [15:0] cnt_q, cnt_d;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dsp_feedback_mac_lanes_if #(.A_W(A_W), .B_W(B_W)) lane_if ();

    assign lane_if.vld = in_valid;
    assign lane_if.clr = clear;
    assign lane_if.sub = subtract;
    assign lane_if.a   = a[g*A_W +: A_W];
    assign lane_if.b   = b[g*B_W +: B_W];

    dsp_mac_lane #(
      .A_W  (A_W),
      .B_W  (B_W),
      .OUT_W(OUT_W),
      .SHIFT(SHIFT)
    ) u_lane (
      .clk_i (clk),
      .rst_ni(reset),
      .bus   (lane_if)
    );

    assign z_out[g*OUT_W +: OUT_W] = lane_if.res.value[OUT_W-1:0];
    assign overflow[g]             = lane_if.res.ovf;

    logic unused_hi;
    assign unused_hi = ^lane_if.res.value[RES_MAX_W-1:OUT_W];
  end

  always_comb begin
    vld_d = in_valid;
    cnt_d = cnt_q;
    if (clear)
      cnt_d = in_valid ? 16'd1 : 16'd0;
    else if (in_valid && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign beat_cnt  = cnt_q;

endmodule
